// File: rtl/rv32i_types.sv
// Shared types for the RV32I pipeline control slice.
package rv32i_types;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned STALL_CNT_W = 32;
  localparam int unsigned FLUSH_CNT_W = 16;

  typedef enum logic [1:0] {
    START     = 2'd0,
    RUN       = 2'd1,
    DMEM_WAIT = 2'd2,
    SQUASH    = 2'd3
  } pipe_ctrl_state_t;

  // Bundle of the five pipeline control strobes.
  typedef struct packed {
    logic go;
    logic stall;
    logic flush;
    logic front_we;
    logic back_we;
  } pipe_ctrl_out_t;

  // Builds a control bundle from individual strobes.
  function automatic pipe_ctrl_out_t ctl_pack(
    input logic go,
    input logic stall,
    input logic flush,
    input logic front_we,
    input logic back_we
  );
    pipe_ctrl_out_t c;
    c.go       = go;
    c.stall    = stall;
    c.flush    = flush;
    c.front_we = front_we;
    c.back_we  = back_we;
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the decode sources and a load in ID/EX.
module hazard_detect
  import rv32i_types::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1_s,
  input  logic [REG_IDX_W-1:0] id_rs2_s,
  input  logic                 ex_memread,
  input  logic [REG_IDX_W-1:0] ex_rd_s,
  output logic                 load_use
);

  // x0 never carries a dependency, so a load targeting it cannot hazard.
  always_comb begin
    load_use = ex_memread && (ex_rd_s != '0) &&
               ((ex_rd_s == id_rs1_s) || (ex_rd_s == id_rs2_s));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: sequences memory waits, branch squashes
// and load-use bubbles, and keeps running stall and flush totals.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// START     | first cycle after reset, all strobes low
// RUN       | normal issue; hazards resolved by priority each cycle
// DMEM_WAIT | whole pipe frozen until data memory responds
// SQUASH    | branch redirected while a fetch was in flight; drop it
module pipe_ctrl
  import rv32i_types::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   imem_resp,
  input  logic                   dmem_req,
  input  logic                   dmem_resp,
  input  logic [REG_IDX_W-1:0]   id_rs1_s,
  input  logic [REG_IDX_W-1:0]   id_rs2_s,
  input  logic                   ex_memread,
  input  logic [REG_IDX_W-1:0]   ex_rd_s,
  input  logic                   br_taken_ex,
  output logic                   go,
  output logic                   stall,
  output logic                   flush,
  output logic                   front_we,
  output logic                   back_we,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [FLUSH_CNT_W-1:0] flush_cnt
);

  pipe_ctrl_state_t       state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  pipe_ctrl_out_t         ctl;
  logic                   load_use;
  logic                   dmem_hold;

  hazard_detect u_hazard_detect (
    .id_rs1_s   (id_rs1_s),
    .id_rs2_s   (id_rs2_s),
    .ex_memread (ex_memread),
    .ex_rd_s    (ex_rd_s),
    .load_use   (load_use)
  );

  // Memory wait: a fresh unanswered request in RUN, or still no response in
  // DMEM_WAIT. Once the response lands, DMEM_WAIT resolves like RUN so the
  // completing cycle is not counted as a stall.
  always_comb begin
    dmem_hold = 1'b0;
    if (state_q == RUN) begin
      dmem_hold = dmem_req && !dmem_resp;
    end else if (state_q == DMEM_WAIT) begin
      dmem_hold = !dmem_resp;
    end
  end

  // Next-state and control strobes, priority dmem > branch > load-use > imem.
  always_comb begin
    state_d = state_q;
    ctl     = '0;
    if (!rst) begin
      state_d = START;
    end else begin
      unique case (state_q)
        START: begin
          state_d = RUN;
        end
        RUN, DMEM_WAIT: begin
          if (dmem_hold) begin
            state_d = DMEM_WAIT;
          end else if (br_taken_ex) begin
            ctl     = ctl_pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            state_d = imem_resp ? RUN : SQUASH;
          end else if (load_use) begin
            ctl     = ctl_pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            state_d = RUN;
          end else if (!imem_resp) begin
            ctl     = ctl_pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            state_d = RUN;
          end else begin
            ctl     = ctl_pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
            state_d = RUN;
          end
        end
        SQUASH: begin
          // The first fetch response after a redirect is the stale one.
          ctl = ctl_pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
          if (imem_resp) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = START;
        end
      endcase
    end
  end

  // Running totals; START is excluded since the front end is idle by design.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q != START) && !ctl.front_we) begin
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
    if (ctl.flush) begin
      flush_cnt_d = flush_cnt_q + {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= START;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign go        = ctl.go;
  assign stall     = ctl.stall;
  assign flush     = ctl.flush;
  assign front_we  = ctl.front_we;
  assign back_we   = ctl.back_we;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Strobe vectors are {go,stall,flush,front_we,back_we}.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_resp;
  logic        dmem_req;
  logic        dmem_resp;
  logic [4:0]  id_rs1_s;
  logic [4:0]  id_rs2_s;
  logic        ex_memread;
  logic [4:0]  ex_rd_s;
  logic        br_taken_ex;
  logic        go;
  logic        stall;
  logic        flush;
  logic        front_we;
  logic        back_we;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] S_ZERO   = 5'b00000;
  localparam logic [4:0] S_NORMAL = 5'b10011;
  localparam logic [4:0] S_STALL  = 5'b01001;
  localparam logic [4:0] S_FLUSH  = 5'b00111;

  pipe_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .imem_resp   (imem_resp),
    .dmem_req    (dmem_req),
    .dmem_resp   (dmem_resp),
    .id_rs1_s    (id_rs1_s),
    .id_rs2_s    (id_rs2_s),
    .ex_memread  (ex_memread),
    .ex_rd_s     (ex_rd_s),
    .br_taken_ex (br_taken_ex),
    .go          (go),
    .stall       (stall),
    .flush       (flush),
    .front_we    (front_we),
    .back_we     (back_we),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flush and stall must never be asserted together.
  always @(negedge clk) begin
    checks++;
    if (stall && flush) begin
      errors++;
      $display("FAIL stall_flush_excl: stall=%b flush=%b required not both 1", stall, flush);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic im, input logic dr, input logic ds, input logic br,
                        input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2);
    imem_resp   = im;
    dmem_req    = dr;
    dmem_resp   = ds;
    br_taken_ex = br;
    ex_memread  = mr;
    ex_rd_s     = rd;
    id_rs1_s    = r1;
    id_rs2_s    = r2;
    #2;
  endtask

  task automatic idle();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    tick();
    tick();
    idle();
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_ZERO) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", {go, stall, flush, front_we, back_we}, S_ZERO);
    end
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    rst = 1'b1;
    idle();
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_ZERO) begin
      errors++;
      $display("FAIL start_outputs: got %b want %b", {go, stall, flush, front_we, back_we}, S_ZERO);
    end
    tick();
    idle();
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_NORMAL) begin
      errors++;
      $display("FAIL run_first: got %b want %b", {go, stall, flush, front_we, back_we}, S_NORMAL);
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL start_not_counted: got %0d want 0", stall_cnt);
    end
    tick();
    idle();
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_NORMAL) begin
      errors++;
      $display("FAIL run_second: got %b want %b", {go, stall, flush, front_we, back_we}, S_NORMAL);
    end
    tick();
  endtask

  task automatic test_load_use();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0);
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_STALL) begin
      errors++;
      $display("FAIL load_use_rs1: got %b want %b", {go, stall, flush, front_we, back_we}, S_STALL);
    end
    tick();
    idle();
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_NORMAL) begin
      errors++;
      $display("FAIL load_use_release: got %b want %b", {go, stall, flush, front_we, back_we}, S_NORMAL);
    end
    checks++;
    if (stall_cnt !== 32'd1) begin
      errors++;
      $display("FAIL load_use_count: got %0d want 1", stall_cnt);
    end
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7);
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_STALL) begin
      errors++;
      $display("FAIL load_use_rs2: got %b want %b", {go, stall, flush, front_we, back_we}, S_STALL);
    end
    tick();
    idle();
    checks++;
    if (stall_cnt !== 32'd2) begin
      errors++;
      $display("FAIL load_use_rs2_count: got %0d want 2", stall_cnt);
    end
    tick();
  endtask

  task automatic test_no_hazard();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_NORMAL) begin
      errors++;
      $display("FAIL x0_no_stall: got %b want %b", {go, stall, flush, front_we, back_we}, S_NORMAL);
    end
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5);
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_NORMAL) begin
      errors++;
      $display("FAIL not_load_no_stall: got %b want %b", {go, stall, flush, front_we, back_we}, S_NORMAL);
    end
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd8, 5'd10);
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_NORMAL) begin
      errors++;
      $display("FAIL no_match_no_stall: got %b want %b", {go, stall, flush, front_we, back_we}, S_NORMAL);
    end
    tick();
    idle();
    checks++;
    if (stall_cnt !== 32'd2) begin
      errors++;
      $display("FAIL no_hazard_count: got %0d want 2", stall_cnt);
    end
  endtask

  task automatic test_imem_wait();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      checks++;
      if ({go, stall, flush, front_we, back_we} !== S_STALL) begin
        errors++;
        $display("FAIL imem_wait_%0d: got %b want %b", i, {go, stall, flush, front_we, back_we}, S_STALL);
      end
      tick();
    end
    idle();
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_NORMAL) begin
      errors++;
      $display("FAIL imem_resume: got %b want %b", {go, stall, flush, front_we, back_we}, S_NORMAL);
    end
    checks++;
    if (stall_cnt !== 32'd4) begin
      errors++;
      $display("FAIL imem_count: got %0d want 4", stall_cnt);
    end
    tick();
  endtask

  task automatic test_dmem_wait();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      checks++;
      if ({go, stall, flush, front_we, back_we} !== S_ZERO) begin
        errors++;
        $display("FAIL dmem_wait_%0d: got %b want %b", i, {go, stall, flush, front_we, back_we}, S_ZERO);
      end
      tick();
    end
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_NORMAL) begin
      errors++;
      $display("FAIL dmem_done: got %b want %b", {go, stall, flush, front_we, back_we}, S_NORMAL);
    end
    tick();
    idle();
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_NORMAL) begin
      errors++;
      $display("FAIL dmem_back_to_run: got %b want %b", {go, stall, flush, front_we, back_we}, S_NORMAL);
    end
    checks++;
    if (stall_cnt !== 32'd7) begin
      errors++;
      $display("FAIL dmem_count: got %0d want 7", stall_cnt);
    end
    tick();
  endtask

  task automatic test_branch_squash();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_FLUSH) begin
      errors++;
      $display("FAIL branch_flush: got %b want %b", {go, stall, flush, front_we, back_we}, S_FLUSH);
    end
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_STALL) begin
      errors++;
      $display("FAIL squash_ignores_br: got %b want %b", {go, stall, flush, front_we, back_we}, S_STALL);
    end
    tick();
    idle();
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_STALL) begin
      errors++;
      $display("FAIL squash_discard: got %b want %b", {go, stall, flush, front_we, back_we}, S_STALL);
    end
    tick();
    idle();
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_NORMAL) begin
      errors++;
      $display("FAIL squash_resume: got %b want %b", {go, stall, flush, front_we, back_we}, S_NORMAL);
    end
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 32'd9) begin
      errors++;
      $display("FAIL squash_counts: got flush=%0d stall=%0d want 1/9", flush_cnt, stall_cnt);
    end
    tick();
  endtask

  task automatic test_branch_hit();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_FLUSH) begin
      errors++;
      $display("FAIL branch_hit_flush: got %b want %b", {go, stall, flush, front_we, back_we}, S_FLUSH);
    end
    tick();
    idle();
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_NORMAL) begin
      errors++;
      $display("FAIL branch_hit_run: got %b want %b", {go, stall, flush, front_we, back_we}, S_NORMAL);
    end
    checks++;
    if (flush_cnt !== 16'd2 || stall_cnt !== 32'd9) begin
      errors++;
      $display("FAIL branch_hit_counts: got flush=%0d stall=%0d want 2/9", flush_cnt, stall_cnt);
    end
    tick();
  endtask

  task automatic test_dmem_priority();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      checks++;
      if ({go, stall, flush, front_we, back_we} !== S_ZERO) begin
        errors++;
        $display("FAIL dmem_over_branch_%0d: got %b want %b", i, {go, stall, flush, front_we, back_we}, S_ZERO);
      end
      tick();
    end
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_FLUSH) begin
      errors++;
      $display("FAIL dmem_then_branch: got %b want %b", {go, stall, flush, front_we, back_we}, S_FLUSH);
    end
    tick();
    idle();
    checks++;
    if (flush_cnt !== 16'd3 || stall_cnt !== 32'd11) begin
      errors++;
      $display("FAIL dmem_prio_counts: got flush=%0d stall=%0d want 3/11", flush_cnt, stall_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd1);
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_STALL) begin
      errors++;
      $display("FAIL b2b_load_use: got %b want %b", {go, stall, flush, front_we, back_we}, S_STALL);
    end
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 5'd4, 5'd1);
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_STALL) begin
      errors++;
      $display("FAIL b2b_imem: got %b want %b", {go, stall, flush, front_we, back_we}, S_STALL);
    end
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd1);
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_FLUSH) begin
      errors++;
      $display("FAIL b2b_branch_over_load: got %b want %b", {go, stall, flush, front_we, back_we}, S_FLUSH);
    end
    tick();
    idle();
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_NORMAL) begin
      errors++;
      $display("FAIL b2b_run: got %b want %b", {go, stall, flush, front_we, back_we}, S_NORMAL);
    end
    checks++;
    if (flush_cnt !== 16'd4 || stall_cnt !== 32'd13) begin
      errors++;
      $display("FAIL b2b_counts: got flush=%0d stall=%0d want 4/13", flush_cnt, stall_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    rst = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    rst = 1'b1;
    idle();
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_ZERO) begin
      errors++;
      $display("FAIL rst_dmem_start: got %b want %b", {go, stall, flush, front_we, back_we}, S_ZERO);
    end
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_counts: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    tick();
    idle();
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_NORMAL) begin
      errors++;
      $display("FAIL rst_dmem_forgotten: got %b want %b", {go, stall, flush, front_we, back_we}, S_NORMAL);
    end
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_ZERO) begin
      errors++;
      $display("FAIL rst_low_in_squash: got %b want %b", {go, stall, flush, front_we, back_we}, S_ZERO);
    end
    tick();
    rst = 1'b1;
    idle();
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_ZERO) begin
      errors++;
      $display("FAIL rst_squash_start: got %b want %b", {go, stall, flush, front_we, back_we}, S_ZERO);
    end
    tick();
    idle();
    checks++;
    if ({go, stall, flush, front_we, back_we} !== S_NORMAL) begin
      errors++;
      $display("FAIL rst_squash_forgotten: got %b want %b", {go, stall, flush, front_we, back_we}, S_NORMAL);
    end
    checks++;
    if (flush_cnt !== 16'd0 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rst_squash_counts: got flush=%0d stall=%0d want 0/0", flush_cnt, stall_cnt);
    end
    tick();
  endtask

  initial begin
    rst = 1'b0;
    imem_resp = 1'b1;
    dmem_req = 1'b0;
    dmem_resp = 1'b0;
    br_taken_ex = 1'b0;
    ex_memread = 1'b0;
    ex_rd_s = 5'd0;
    id_rs1_s = 5'd0;
    id_rs2_s = 5'd0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_imem_wait();
    test_dmem_wait();
    test_branch_squash();
    test_branch_hit();
    test_dmem_priority();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
